zone_frame_sched: RTL and testbench

Frame-level sequencer for the ambient-light zone accumulators. It takes the downscaled pixel stream, stamps each pixel with its grid row and column, and issues the per-pixel accumulate strobe that all `cal_block` zone instances share. It clears the accumulators at frame start and snapshots them at frame end. It then steps through every zone in order, handing each zone's colour to the LED serialiser over a valid/ready handshake, and finally holds the WS2812 latch gap before it accepts the next frame.

---
 rtl/zone_frame_sched.sv | 156 +++++++++++++++
 tb/tb_zone_frame_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zone_frame_sched.sv
// Frame sequencer for the ambient-light zone accumulators: stamps pixels with grid
// coordinates, issues clear/accumulate/snapshot strobes, then reads zones out to the LEDs.
module zone_frame_sched #(
   parameter int ROWS      = 72,
   parameter int COLS      = 128,
   parameter int NUM_ZONES = 32,
   parameter int LATCH_CYC = 5000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_valid,
   input  logic        pix_sof,
   input  logic [23:0] pix_grb,
   output logic [23:0] grb_out,
   output logic [6:0]  row_now,
   output logic [6:0]  col_now,
   output logic        data_rd,
   output logic        acc_clr,
   output logic        snap,
   output logic [5:0]  zone_idx,
   output logic        led_valid,
   input  logic        led_ready,
   output logic        busy,
   output logic        frame_err,
   output logic [7:0]  drop_cnt
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ACCUM = 3'd1;
   localparam logic [2:0] S_SNAP  = 3'd2;
   localparam logic [2:0] S_SEND  = 3'd3;
   localparam logic [2:0] S_LATCH = 3'd4;

   localparam logic [6:0]    LAST_ROW  = 7'(ROWS - 1);
   localparam logic [6:0]    LAST_COL  = 7'(COLS - 1);
   localparam logic [5:0]    LAST_ZONE = 6'(NUM_ZONES - 1);
   localparam int            LW        = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;
   localparam logic [LW-1:0] LAST_LAT  = LW'(LATCH_CYC - 1);

   logic [2:0]    state;
   logic          done;
   logic [6:0]    row_c, col_c;
   logic [LW-1:0] lat_cnt;
   logic          s1_vld, s1_last, s2_last;
   logic [23:0]   s1_grb;
   logic [6:0]    s1_row, s1_col;
   logic          sof_in, accept, restart, at_last, dropping;
   logic [6:0]    pix_row, pix_col;

   // done: last pixel taken, waiting for its accumulate strobe before snapshotting
   always_comb begin
      sof_in  = pix_valid & pix_sof;
      accept  = 1'b0;
      restart = 1'b0;
      if (state == S_IDLE) begin
         accept = sof_in;
      end else if (state == S_ACCUM && !done) begin
         accept  = pix_valid;
         restart = sof_in;
      end
      pix_row  = sof_in ? 7'd0 : row_c;
      pix_col  = sof_in ? 7'd0 : col_c;
      at_last  = (pix_row == LAST_ROW) && (pix_col == LAST_COL);
      dropping = sof_in && ((state == S_ACCUM && done) || state == S_SNAP ||
                            state == S_SEND || state == S_LATCH);
   end

   assign snap      = (state == S_SNAP);
   assign led_valid = (state == S_SEND);
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_clr   <= 1'b0;
         frame_err <= 1'b0;
         s1_vld    <= 1'b0;
         s1_last   <= 1'b0;
         s2_last   <= 1'b0;
         s1_grb    <= '0;
         s1_row    <= '0;
         s1_col    <= '0;
         row_c     <= '0;
         col_c     <= '0;
         data_rd   <= 1'b0;
         grb_out   <= '0;
         row_now   <= '0;
         col_now   <= '0;
         drop_cnt  <= '0;
      end else begin
         acc_clr   <= accept & sof_in;
         frame_err <= restart;
         s1_vld    <= accept;
         s1_last   <= accept & at_last;
         s2_last   <= s1_last;
         data_rd   <= s1_vld;
         if (accept) begin
            s1_grb <= pix_grb;
            s1_row <= pix_row;
            s1_col <= pix_col;
            if (pix_col == LAST_COL) begin
               col_c <= 7'd0;
               row_c <= pix_row + 7'd1;
            end else begin
               col_c <= pix_col + 7'd1;
               row_c <= pix_row;
            end
         end
         if (s1_vld) begin
            grb_out <= s1_grb;
            row_now <= s1_row;
            col_now <= s1_col;
         end
         if (dropping && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         done     <= 1'b0;
         zone_idx <= '0;
         lat_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: if (accept) begin
               state <= S_ACCUM;
               done  <= at_last;
            end
            S_ACCUM: begin
               if (accept && at_last) done <= 1'b1;
               if (s2_last) begin
                  state <= S_SNAP;
                  done  <= 1'b0;
               end
            end
            S_SNAP: begin
               state    <= S_SEND;
               zone_idx <= '0;
            end
            S_SEND: if (led_ready) begin
               if (zone_idx == LAST_ZONE) begin
                  state    <= S_LATCH;
                  zone_idx <= '0;
                  lat_cnt  <= '0;
               end else begin
                  zone_idx <= zone_idx + 6'd1;
               end
            end
            S_LATCH: begin
               if (lat_cnt == LAST_LAT) state <= S_IDLE;
               else lat_cnt <= lat_cnt + LW'(1);
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_zone_frame_sched.sv
// Bench for zone_frame_sched: a per-cycle timeline model of the frame rules, directed
// scenarios with hand-computed cycle expectations, then randomized traffic.
module tb_zone_frame_sched;
   localparam int ROWS = 4, COLS = 4, NZ = 3, LAT = 5;
   localparam int P_IDLE = 0, P_ACCUM = 1, P_WAIT = 2, P_SNAP = 3, P_SEND = 4, P_LATCH = 5;

   logic        clk = 1'b1;
   logic        rst = 1'b0;
   logic        pix_valid = 1'b0, pix_sof = 1'b0, led_ready = 1'b0;
   logic [23:0] pix_grb = '0;
   logic [23:0] grb_out;
   logic [6:0]  row_now, col_now;
   logic        data_rd, acc_clr, snap, led_valid, busy, frame_err;
   logic [5:0]  zone_idx;
   logic [7:0]  drop_cnt;

   zone_frame_sched #(.ROWS(ROWS), .COLS(COLS), .NUM_ZONES(NZ), .LATCH_CYC(LAT)) dut (
      .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_grb(pix_grb),
      .grb_out(grb_out), .row_now(row_now), .col_now(col_now), .data_rd(data_rd),
      .acc_clr(acc_clr), .snap(snap), .zone_idx(zone_idx), .led_valid(led_valid),
      .led_ready(led_ready), .busy(busy), .frame_err(frame_err), .drop_cnt(drop_cnt));

   always #5 clk = ~clk;

   int cyc = 0, n_tests = 0, n_fail = 0;
   // model: frame phase plus an 8-slot timeline of scheduled strobes
   int ph = P_IDLE, pidx = 0, zk = 0, lat_left = 0, drop = 0, snap_at = -1;
   bit          m_rd[8], m_clr[8], m_err[8];
   logic [23:0] m_grb[8];
   int          m_row[8], m_col[8];
   // event log used by the hand-computed checks
   int rd_cnt = 0, clr_cnt = 0, err_cnt = 0, lv_cnt = 0, busy_cnt = 0;
   int clr_c = -1, err_c = -1, snap_c = -1, lv_rise = -1, busy_last = -1;
   int last_row = -1, last_col = -1;
   bit lv_prev = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
      end
   endtask

   task automatic compare();
      int s = cyc % 8;
      if (!rst) begin
         chk("rst_grb", grb_out, 0);    chk("rst_row", row_now, 0);
         chk("rst_col", col_now, 0);    chk("rst_rd", data_rd, 0);
         chk("rst_clr", acc_clr, 0);    chk("rst_snap", snap, 0);
         chk("rst_zone", zone_idx, 0);  chk("rst_lv", led_valid, 0);
         chk("rst_busy", busy, 0);      chk("rst_err", frame_err, 0);
         chk("rst_drop", drop_cnt, 0);
      end else begin
         chk("data_rd", data_rd, m_rd[s]);
         if (m_rd[s]) begin
            chk("grb_out", grb_out, m_grb[s]);
            chk("row_now", row_now, m_row[s]);
            chk("col_now", col_now, m_col[s]);
         end
         chk("acc_clr", acc_clr, m_clr[s]);
         chk("frame_err", frame_err, m_err[s]);
         chk("snap", snap, ph == P_SNAP);
         chk("led_valid", led_valid, ph == P_SEND);
         if (ph == P_SEND) chk("zone_idx", zone_idx, zk);
         chk("busy", busy, ph != P_IDLE);
         chk("drop_cnt", drop_cnt, drop);
      end
      if (data_rd) begin rd_cnt++; last_row = row_now; last_col = col_now; end
      if (acc_clr) begin clr_cnt++; clr_c = cyc; end
      if (frame_err) begin err_cnt++; err_c = cyc; end
      if (snap) snap_c = cyc;
      if (led_valid) lv_cnt++;
      if (led_valid && !lv_prev) lv_rise = cyc;
      lv_prev = led_valid;
      if (busy) begin busy_cnt++; busy_last = cyc; end
   endtask

   task automatic take_pixel();
      int s = (cyc + 2) % 8;
      m_rd[s]  = 1;
      m_grb[s] = pix_grb;
      m_row[s] = pidx / COLS;
      m_col[s] = pidx % COLS;
      pidx++;
      if (pidx == ROWS * COLS) begin
         ph = P_WAIT;
         snap_at = cyc + 3;
      end
   endtask

   task automatic model();
      bit sofv = pix_valid && pix_sof;
      if (!rst) begin
         ph = P_IDLE; pidx = 0; zk = 0; lat_left = 0; drop = 0; snap_at = -1;
         for (int i = 0; i < 8; i++) begin m_rd[i] = 0; m_clr[i] = 0; m_err[i] = 0; end
      end else begin
         if (sofv && ph >= P_WAIT && drop < 255) drop++;
         case (ph)
            P_IDLE: if (sofv) begin
               m_clr[(cyc + 1) % 8] = 1;
               ph = P_ACCUM;
               pidx = 0;
               take_pixel();
            end
            P_ACCUM: if (pix_valid) begin
               if (pix_sof) begin
                  m_err[(cyc + 1) % 8] = 1;
                  m_clr[(cyc + 1) % 8] = 1;
                  pidx = 0;
               end
               take_pixel();
            end
            P_WAIT: if (cyc + 1 == snap_at) ph = P_SNAP;
            P_SNAP: begin ph = P_SEND; zk = 0; end
            P_SEND: if (led_ready) begin
               if (zk == NZ - 1) begin ph = P_LATCH; lat_left = LAT; end
               else zk++;
            end
            P_LATCH: begin
               lat_left--;
               if (lat_left == 0) ph = P_IDLE;
            end
            default: ph = P_IDLE;
         endcase
         m_rd[cyc % 8] = 0; m_clr[cyc % 8] = 0; m_err[cyc % 8] = 0;
      end
      cyc++;
   endtask

   // inputs are already set for cycle cyc; compare mid-cycle, advance model at the edge
   task automatic tick();
      @(negedge clk);
      compare();
      @(posedge clk);
      model();
      #1;
   endtask

   task automatic pix(input bit v, input bit s);
      pix_valid = v;
      pix_sof   = s;
      pix_grb   = 24'($urandom);
      tick();
   endtask

   task automatic idle(input int n);
      pix_valid = 0;
      pix_sof   = 0;
      repeat (n) tick();
   endtask

   task automatic frame();
      for (int i = 0; i < ROWS * COLS; i++) pix(1, i == 0);
      pix_valid = 0;
      pix_sof   = 0;
   endtask

   task automatic wait_send(input int budget);
      int n = 0;
      while (ph != P_SEND && n < budget) begin tick(); n++; end
      chk("wait_send_timeout", n < budget, 1);
      chk("wait_send_lv", led_valid, 1);
   endtask

   int s0, b_rd, b_clr, b_err, b_lv, b_busy;

   initial begin
      repeat (3) tick();
      rst = 1;
      idle(2);

      // full frame, sink always ready
      led_ready = 1;
      s0 = cyc; b_rd = rd_cnt; b_clr = clr_cnt; b_lv = lv_cnt;
      frame();
      idle(30);
      chk("ff_clr_cycle", clr_c, s0 + 1);
      chk("ff_clr_count", clr_cnt - b_clr, 1);
      chk("ff_rd_count", rd_cnt - b_rd, 16);
      chk("ff_last_row", last_row, 3);
      chk("ff_last_col", last_col, 3);
      chk("ff_snap_cycle", snap_c, s0 + 18);
      chk("ff_lv_first", lv_rise, s0 + 19);
      chk("ff_lv_cycles", lv_cnt - b_lv, 3);
      chk("ff_busy_last", busy_last, s0 + 26);

      // gapped input, stalled sink at zone 1
      led_ready = 0; b_rd = rd_cnt; b_lv = lv_cnt;
      for (int i = 0; i < ROWS * COLS; i++) begin pix(1, i == 0); pix(0, 0); end
      wait_send(20);
      led_ready = 1; tick();
      led_ready = 0; repeat (4) tick();
      led_ready = 1; idle(20);
      chk("gap_rd_count", rd_cnt - b_rd, 16);
      chk("stall_lv_cycles", lv_cnt - b_lv, 7);

      // short frame: restart on the eighth pixel
      b_rd = rd_cnt; b_clr = clr_cnt; b_err = err_cnt;
      for (int i = 0; i < 7; i++) pix(1, i == 0);
      s0 = cyc;
      frame();
      idle(30);
      chk("short_err_count", err_cnt - b_err, 1);
      chk("short_err_cycle", err_c, s0 + 1);
      chk("short_clr_count", clr_cnt - b_clr, 2);
      chk("short_rd_count", rd_cnt - b_rd, 23);
      chk("short_last_row", last_row, 3);
      chk("short_last_col", last_col, 3);

      // one frame dropped while sending
      led_ready = 0;
      frame();
      wait_send(20);
      b_rd = rd_cnt;
      frame();
      chk("drop_one", drop_cnt, 1);
      chk("drop_no_rd", rd_cnt - b_rd, 0);
      led_ready = 1; idle(20);

      // saturation
      led_ready = 0;
      frame();
      wait_send(20);
      repeat (300) pix(1, 1);
      chk("drop_sat", drop_cnt, 255);
      led_ready = 1; idle(20);

      // reset during SEND
      led_ready = 0;
      frame();
      wait_send(20);
      rst = 0;
      #1;
      chk("rst_send_lv", led_valid, 0);
      chk("rst_send_busy", busy, 0);
      chk("rst_send_drop", drop_cnt, 0);
      idle(2);
      rst = 1; led_ready = 1;
      idle(5);

      // pixels without start-of-frame while idle
      b_rd = rd_cnt; b_busy = busy_cnt;
      repeat (10) pix(1, 0);
      idle(3);
      chk("nosof_rd", rd_cnt - b_rd, 0);
      chk("nosof_busy", busy_cnt - b_busy, 0);

      // randomized traffic with occasional reset pulses
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 599) != 0);
         led_ready = ($urandom_range(0, 2) != 0);
         pix_valid = ($urandom_range(0, 3) != 0);
         pix_sof   = pix_valid && ($urandom_range(0, 19) == 0);
         pix_grb   = 24'($urandom);
         tick();
      end
      rst = 1; led_ready = 1;
      idle(40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
      $fatal(1, "watchdog");
   end
endmodule
